axi_lite_to_reg: RTL and testbench

//  AXI-Lite device endpoint that converts AXI-Lite transactions into a simple single-port register bus for CSR blocks.

---
 rtl/axi_lite_to_reg_if.sv | 58 +++++
 rtl/axi_lite_to_reg.sv | 195 +++++++++++++++++++
 tb/tb_axi_lite_to_reg.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_to_reg_if.sv
// AXI-Lite host-side bundle for axi_lite_to_reg.
// Five channels (AW, W, B, AR, R). The endpoint takes the slave modport and the
// upstream register slice (or a testbench) takes the master modport.
interface axi_lite_to_reg_if #(
    parameter int DataWidth = 64,
    parameter int AddrWidth = 56
);
    localparam int StrbWidth = DataWidth / 8;

    // AW channel
    logic                 aw_valid;
    logic                 aw_ready;
    logic [AddrWidth-1:0] aw_addr;
    logic [2:0]           aw_prot;

    // W channel
    logic                 w_valid;
    logic                 w_ready;
    logic [DataWidth-1:0] w_data;
    logic [StrbWidth-1:0] w_strb;

    // B channel
    logic                 b_valid;
    logic                 b_ready;
    logic [1:0]           b_resp;

    // AR channel
    logic                 ar_valid;
    logic                 ar_ready;
    logic [AddrWidth-1:0] ar_addr;
    logic [2:0]           ar_prot;

    // R channel
    logic                 r_valid;
    logic                 r_ready;
    logic [DataWidth-1:0] r_data;
    logic [1:0]           r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot,
        output w_valid, w_data, w_strb,
        output b_ready,
        output ar_valid, ar_addr, ar_prot,
        output r_ready,
        input  aw_ready, w_ready, b_valid, b_resp,
        input  ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, aw_prot,
        input  w_valid, w_data, w_strb,
        input  b_ready,
        input  ar_valid, ar_addr, ar_prot,
        input  r_ready,
        output aw_ready, w_ready, b_valid, b_resp,
        output ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi_lite_to_reg.sv
// AXI-Lite endpoint that bridges onto a single-port CSR register bus.
// Handles one transaction at a time: arbitrate in IDLE, issue in REQ, wait for
// the register response (with optional timeout) in WAIT, answer on B/R in RESP.
// Misaligned accesses never reach the register bus and answer SLVERR.
// DataWidth is expected to be 32 or 64.
module axi_lite_to_reg #(
    parameter int DataWidth     = 64,
    parameter int AddrWidth     = 56,
    parameter int TimeoutCycles = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    axi_lite_to_reg_if.slave       host,

    output logic                   reg_req_valid,
    input  logic                   reg_req_ready,
    output logic                   reg_req_write,
    output logic [AddrWidth-1:0]   reg_req_addr,
    output logic [DataWidth-1:0]   reg_req_wdata,
    output logic [DataWidth/8-1:0] reg_req_wstrb,
    input  logic                   reg_rsp_valid,
    input  logic [DataWidth-1:0]   reg_rsp_rdata,
    input  logic                   reg_rsp_error
);
    localparam int StrbWidth = DataWidth / 8;
    localparam int OffWidth  = $clog2(StrbWidth);
    localparam int CntWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntWidth-1:0] CntLast =
        (TimeoutCycles > 0) ? CntWidth'(TimeoutCycles - 1) : '0;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e                 state_q,    state_d;
    logic                   is_write_q, is_write_d;
    logic [AddrWidth-1:0]   addr_q,     addr_d;
    logic [DataWidth-1:0]   wdata_q,    wdata_d;
    logic [StrbWidth-1:0]   wstrb_q,    wstrb_d;
    logic [2:0]             prot_q,     prot_d;
    logic [1:0]             resp_q,     resp_d;
    logic [DataWidth-1:0]   rdata_q,    rdata_d;
    logic                   prio_wr_q,  prio_wr_d;
    logic [CntWidth-1:0]    cnt_q,      cnt_d;

    logic wr_elig;
    logic rd_elig;
    logic grant_wr;
    logic grant_rd;
    logic aw_misaligned;
    logic ar_misaligned;
    logic host_resp_taken;

    // prot is captured for future use; nothing downstream consumes it yet.
    logic prot_unused;
    assign prot_unused = ^prot_q;

    // Arbitration: a write needs AW and W together; ties follow prio_wr.
    assign wr_elig  = host.aw_valid && host.w_valid;
    assign rd_elig  = host.ar_valid;
    assign grant_wr = (state_q == ST_IDLE) && wr_elig && (prio_wr_q || !rd_elig);
    assign grant_rd = (state_q == ST_IDLE) && rd_elig && !grant_wr;

    assign aw_misaligned = |host.aw_addr[OffWidth-1:0];
    assign ar_misaligned = |host.ar_addr[OffWidth-1:0];

    assign host_resp_taken = is_write_q ? host.b_ready : host.r_ready;

    // AW and W are always accepted together so a write is never split.
    assign host.aw_ready = grant_wr;
    assign host.w_ready  = grant_wr;
    assign host.ar_ready = grant_rd;

    assign host.b_valid  = (state_q == ST_RESP) &&  is_write_q;
    assign host.r_valid  = (state_q == ST_RESP) && !is_write_q;
    assign host.b_resp   = resp_q;
    assign host.r_resp   = resp_q;
    assign host.r_data   = rdata_q;

    assign reg_req_valid = (state_q == ST_REQ);
    assign reg_req_write = is_write_q;
    assign reg_req_addr  = addr_q;
    assign reg_req_wdata = wdata_q;
    assign reg_req_wstrb = wstrb_q;

    // Next-state and datapath updates for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        prot_d     = prot_q;
        resp_d     = resp_q;
        rdata_d    = rdata_q;
        prio_wr_d  = prio_wr_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_wr) begin
                    is_write_d = 1'b1;
                    addr_d     = host.aw_addr;
                    wdata_d    = host.w_data;
                    wstrb_d    = host.w_strb;
                    prot_d     = host.aw_prot;
                    prio_wr_d  = ~prio_wr_q;
                    if (aw_misaligned) begin
                        resp_d  = RespSlvErr;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (grant_rd) begin
                    is_write_d = 1'b0;
                    addr_d     = host.ar_addr;
                    prot_d     = host.ar_prot;
                    prio_wr_d  = ~prio_wr_q;
                    if (ar_misaligned) begin
                        resp_d  = RespSlvErr;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (reg_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // A response arriving in the last allowed cycle still wins.
                if (reg_rsp_valid) begin
                    rdata_d = reg_rsp_rdata;
                    resp_d  = reg_rsp_error ? RespSlvErr : RespOkay;
                    state_d = ST_RESP;
                end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
                    rdata_d = '0;
                    resp_d  = RespDecErr;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end

            ST_RESP: begin
                if (host_resp_taken) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            prot_q     <= '0;
            resp_q     <= '0;
            rdata_q    <= '0;
            prio_wr_q  <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            prot_q     <= prot_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
            prio_wr_q  <= prio_wr_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_to_reg.sv
// Bench for axi_lite_to_reg: directed scenarios followed by randomized single
// transactions, all predicted from bus-level rules (latency, response codes,
// what reaches the register bus) rather than from the FSM internals.
module tb_axi_lite_to_reg;
    localparam int DW = 64;
    localparam int AW = 56;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    axi_lite_to_reg_if #(.DataWidth(DW), .AddrWidth(AW)) host ();

    logic          reg_req_valid;
    logic          reg_req_ready;
    logic          reg_req_write;
    logic [AW-1:0] reg_req_addr;
    logic [DW-1:0] reg_req_wdata;
    logic [SW-1:0] reg_req_wstrb;
    logic          reg_rsp_valid;
    logic [DW-1:0] reg_rsp_rdata;
    logic          reg_rsp_error;

    axi_lite_to_reg #(.DataWidth(DW), .AddrWidth(AW), .TimeoutCycles(TO)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .host          (host),
        .reg_req_valid (reg_req_valid),
        .reg_req_ready (reg_req_ready),
        .reg_req_write (reg_req_write),
        .reg_req_addr  (reg_req_addr),
        .reg_req_wdata (reg_req_wdata),
        .reg_req_wstrb (reg_req_wstrb),
        .reg_rsp_valid (reg_rsp_valid),
        .reg_rsp_rdata (reg_rsp_rdata),
        .reg_rsp_error (reg_rsp_error)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register-bus responder knobs, set by the main sequence per transaction.
    int            s_rdy_dly = 0;
    int            s_rsp_dly = 1;
    int            s_late    = 0;
    logic          s_err     = 1'b0;
    logic          s_mute    = 1'b0;
    logic [DW-1:0] s_rdata   = '0;
    req_t          seen_q[$];

    // Register-bus responder: logs every request, checks it is held while
    // ready is withheld, and answers (or stays silent, optionally late).
    initial begin : reg_slave
        req_t cur;
        reg_req_ready = 1'b0;
        reg_rsp_valid = 1'b0;
        reg_rsp_rdata = '0;
        reg_rsp_error = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && reg_req_valid) begin
                cur.wr    = reg_req_write;
                cur.addr  = reg_req_addr;
                cur.wdata = reg_req_wdata;
                cur.wstrb = reg_req_wstrb;
                repeat (s_rdy_dly) begin
                    @(negedge clk_i);
                    chk("req_hold_valid", 64'(reg_req_valid), 64'd1);
                    chk("req_hold_addr", 64'(reg_req_addr), 64'(cur.addr));
                    chk("req_hold_wdata", reg_req_wdata, cur.wdata);
                end
                reg_req_ready = 1'b1;
                seen_q.push_back(cur);
                @(negedge clk_i);
                reg_req_ready = 1'b0;
                if (!s_mute) begin
                    repeat (s_rsp_dly - 1) @(negedge clk_i);
                    reg_rsp_valid = 1'b1;
                    reg_rsp_rdata = s_rdata;
                    reg_rsp_error = s_err;
                    @(negedge clk_i);
                    reg_rsp_valid = 1'b0;
                    reg_rsp_rdata = '0;
                    reg_rsp_error = 1'b0;
                end else if (s_late > 0) begin
                    repeat (s_late) @(negedge clk_i);
                    reg_rsp_valid = 1'b1;
                    reg_rsp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                    reg_rsp_error = 1'b1;
                    @(negedge clk_i);
                    reg_rsp_valid = 1'b0;
                    reg_rsp_rdata = '0;
                    reg_rsp_error = 1'b0;
                end
            end
        end
    end

    // While a response is withheld, offer new AW/W/AR and require they stay
    // unaccepted and the response stays put.
    task automatic hold_resp(input int bp, input logic is_wr, input logic [DW-1:0] d0,
                             input logic [1:0] r0);
        if (bp > 0) begin
            host.aw_valid = 1'b1;
            host.w_valid  = 1'b1;
            host.ar_valid = 1'b1;
            for (int i = 0; i < bp; i++) begin
                #1;
                chk("busy_aw_ready", 64'(host.aw_ready), 64'd0);
                chk("busy_ar_ready", 64'(host.ar_ready), 64'd0);
                if (is_wr) begin
                    chk("bp_b_valid", 64'(host.b_valid), 64'd1);
                    chk("bp_b_resp", 64'(host.b_resp), 64'(r0));
                end else begin
                    chk("bp_r_valid", 64'(host.r_valid), 64'd1);
                    chk("bp_r_data", host.r_data, d0);
                end
                @(negedge clk_i);
            end
            host.aw_valid = 1'b0;
            host.w_valid  = 1'b0;
            host.ar_valid = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int bp,
                            output logic [DW-1:0] d, output logic [1:0] r, output int lat);
        int n;
        @(negedge clk_i);
        host.ar_valid = 1'b1;
        host.ar_addr  = a;
        host.ar_prot  = 3'($urandom_range(7));
        #1;
        n = 0;
        while (!host.ar_ready && n < 64) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("ar_accept", 64'(host.ar_ready), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        host.ar_valid = 1'b0;
        lat = 1;
        while (!host.r_valid && lat < 64) begin
            @(negedge clk_i);
            lat++;
        end
        chk("r_valid_seen", 64'(host.r_valid), 64'd1);
        d = host.r_data;
        r = host.r_resp;
        hold_resp(bp, 1'b0, d, r);
        host.r_ready = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        host.r_ready = 1'b0;
        chk("r_valid_drop", 64'(host.r_valid), 64'd0);
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input logic [SW-1:0] ws, input int bp,
                             output logic [1:0] r, output int lat);
        int n;
        @(negedge clk_i);
        host.aw_valid = 1'b1;
        host.aw_addr  = a;
        host.aw_prot  = 3'($urandom_range(7));
        host.w_valid  = 1'b1;
        host.w_data   = wd;
        host.w_strb   = ws;
        #1;
        n = 0;
        while (!host.aw_ready && n < 64) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("aw_accept", 64'(host.aw_ready), 64'd1);
        chk("w_accept", 64'(host.w_ready), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        host.aw_valid = 1'b0;
        host.w_valid  = 1'b0;
        lat = 1;
        while (!host.b_valid && lat < 64) begin
            @(negedge clk_i);
            lat++;
        end
        chk("b_valid_seen", 64'(host.b_valid), 64'd1);
        r = host.b_resp;
        hold_resp(bp, 1'b1, '0, r);
        host.b_ready = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        host.b_ready = 1'b0;
        chk("b_valid_drop", 64'(host.b_valid), 64'd0);
    endtask

    // Pops the one logged register request (if any is expected) and compares it.
    task automatic chk_req(input logic exp_issued, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [SW-1:0] ws);
        req_t q;
        chk("req_count", 64'(seen_q.size()), exp_issued ? 64'd1 : 64'd0);
        if (seen_q.size() > 0) begin
            q = seen_q.pop_front();
            chk("req_write", 64'(q.wr), 64'(wr));
            chk("req_addr", 64'(q.addr), 64'(a));
            if (wr) begin
                chk("req_wdata", q.wdata, wd);
                chk("req_wstrb", 64'(q.wstrb), 64'(ws));
            end
        end
        seen_q.delete();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DW-1:0] d;
        logic [DW-1:0] tmp;
        logic [DW-1:0] wd;
        logic [SW-1:0] ws;
        logic [AW-1:0] a;
        logic [1:0]    r;
        logic [1:0]    er;
        logic [DW-1:0] ed;
        logic          wr;
        logic          mis;
        logic          stray;
        int            lat;
        int            elat;
        int            bp;
        int            ng;
        int            n;

        host.aw_valid = 1'b0; host.aw_addr = '0; host.aw_prot = '0;
        host.w_valid  = 1'b0; host.w_data  = '0; host.w_strb  = '0;
        host.b_ready  = 1'b0;
        host.ar_valid = 1'b0; host.ar_addr = '0; host.ar_prot = '0;
        host.r_ready  = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_b_valid", 64'(host.b_valid), 64'd0);
        chk("rst_r_valid", 64'(host.r_valid), 64'd0);
        chk("rst_req_valid", 64'(reg_req_valid), 64'd0);
        chk("rst_aw_ready", 64'(host.aw_ready), 64'd0);
        chk("rst_ar_ready", 64'(host.ar_ready), 64'd0);
        chk("rst_r_data", host.r_data, 64'd0);
        chk("rst_r_resp", 64'(host.r_resp), 64'd0);
        chk("rst_b_resp", 64'(host.b_resp), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // AW, W and AR all pending: grants alternate starting with the write.
        s_rdy_dly = 0; s_rsp_dly = 1; s_err = 1'b0; s_mute = 1'b0; s_rdata = 64'h77;
        @(negedge clk_i);
        host.aw_addr = 56'h100; host.w_data = 64'h55; host.w_strb = '1;
        host.ar_addr = 56'h200;
        host.aw_valid = 1'b1; host.w_valid = 1'b1; host.ar_valid = 1'b1;
        host.b_ready = 1'b1; host.r_ready = 1'b1;
        ng = 0;
        n  = 0;
        while (ng < 6 && n < 200) begin
            #1;
            if (host.aw_ready || host.w_ready || host.ar_ready) begin
                chk("grant_aw_w_pair", 64'(host.w_ready), 64'(host.aw_ready));
                chk("grant_is_write", 64'(host.aw_ready), (ng % 2 == 0) ? 64'd1 : 64'd0);
                chk("grant_not_both", 64'(host.aw_ready && host.ar_ready), 64'd0);
                ng++;
            end
            @(negedge clk_i);
            n++;
        end
        host.aw_valid = 1'b0; host.w_valid = 1'b0; host.ar_valid = 1'b0;
        chk("grant_count", 64'(ng), 64'd6);
        repeat (10) @(negedge clk_i);
        host.b_ready = 1'b0; host.r_ready = 1'b0;
        chk("alt_req_count", 64'(seen_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < seen_q.size(); i++) begin
            chk("alt_req_write", 64'(seen_q[i].wr), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("alt_req_addr", 64'(seen_q[i].addr), (i % 2 == 0) ? 64'h100 : 64'h200);
        end
        seen_q.delete();

        // Zero-wait read.
        s_rdata = 64'hDEAD_BEEF;
        axi_read(56'h10, 0, d, r, lat);
        chk("rd0_data", d, 64'hDEAD_BEEF);
        chk("rd0_resp", 64'(r), 64'd0);
        chk("rd0_latency", 64'(lat), 64'd3);
        chk_req(1'b1, 1'b0, 56'h10, '0, '0);

        // Plain write.
        axi_write(56'h18, 64'h1234, 8'hFF, 0, r, lat);
        chk("wr0_resp", 64'(r), 64'd0);
        chk("wr0_latency", 64'(lat), 64'd3);
        chk_req(1'b1, 1'b1, 56'h18, 64'h1234, 8'hFF);

        // Zero strobes still reach the register bus.
        axi_write(56'h20, 64'hCAFE, 8'h00, 0, r, lat);
        chk("wr_nostrb_resp", 64'(r), 64'd0);
        chk_req(1'b1, 1'b1, 56'h20, 64'hCAFE, 8'h00);

        // Misaligned read and write never reach the register bus.
        s_rdata = 64'h1111_2222;
        axi_read(56'h14, 0, d, r, lat);
        chk("mis_rd_resp", 64'(r), 64'd2);
        chk("mis_rd_data", d, 64'd0);
        chk("mis_rd_latency", 64'(lat), 64'd1);
        chk_req(1'b0, 1'b0, '0, '0, '0);
        axi_write(56'h1C, 64'h99, 8'h0F, 0, r, lat);
        chk("mis_wr_resp", 64'(r), 64'd2);
        chk_req(1'b0, 1'b1, '0, '0, '0);

        // Register error on a write.
        s_err = 1'b1;
        axi_write(56'h28, 64'h5A5A, 8'h3C, 0, r, lat);
        chk("err_wr_resp", 64'(r), 64'd2);
        chk_req(1'b1, 1'b1, 56'h28, 64'h5A5A, 8'h3C);
        s_err = 1'b0;

        // Timeout, late response discarded, next read normal.
        s_mute = 1'b1; s_late = 5;
        axi_read(56'h40, 0, d, r, lat);
        chk("to_resp", 64'(r), 64'd3);
        chk("to_data", d, 64'd0);
        chk("to_latency", 64'(lat), 64'(2 + TO));
        chk_req(1'b1, 1'b0, 56'h40, '0, '0);
        s_mute = 1'b0; s_late = 0; s_rdata = 64'h0123_4567_89AB_CDEF;
        axi_read(56'h48, 0, d, r, lat);
        chk("post_to_data", d, 64'h0123_4567_89AB_CDEF);
        chk("post_to_resp", 64'(r), 64'd0);
        chk("post_to_latency", 64'(lat), 64'd3);
        chk_req(1'b1, 1'b0, 56'h48, '0, '0);

        // B backpressure for 5 cycles.
        axi_write(56'h30, 64'hF00D, 8'hF0, 5, r, lat);
        chk("bp_wr_resp", 64'(r), 64'd0);
        chk_req(1'b1, 1'b1, 56'h30, 64'hF00D, 8'hF0);

        // Reset while waiting on the register bus drops the transaction.
        s_mute = 1'b1; s_late = 0;
        @(negedge clk_i);
        host.ar_valid = 1'b1; host.ar_addr = 56'h80;
        #1;
        n = 0;
        while (!host.ar_ready && n < 64) begin
            @(negedge clk_i); #1; n++;
        end
        chk("rw_ar_accept", 64'(host.ar_ready), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        host.ar_valid = 1'b0;
        n = 0;
        while (seen_q.size() == 0 && n < 64) begin
            @(negedge clk_i); n++;
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("rw_req_valid", 64'(reg_req_valid), 64'd0);
        chk("rw_r_valid", 64'(host.r_valid), 64'd0);
        chk("rw_b_valid", 64'(host.b_valid), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        host.r_ready = 1'b1;
        stray = 1'b0;
        repeat (8) begin
            @(negedge clk_i);
            if (host.r_valid || host.b_valid || reg_req_valid) stray = 1'b1;
        end
        host.r_ready = 1'b0;
        chk("rw_no_response", 64'(stray), 64'd0);
        seen_q.delete();
        s_mute = 1'b0; s_rdata = 64'hABCD;
        axi_read(56'h88, 0, d, r, lat);
        chk("rw_next_data", d, 64'hABCD);
        chk("rw_next_resp", 64'(r), 64'd0);
        chk_req(1'b1, 1'b0, 56'h88, '0, '0);

        // Randomized single transactions against the bus-level model.
        for (int t = 0; t < 40; t++) begin
            wr   = 1'($urandom_range(1));
            mis  = ($urandom_range(5) == 0);
            tmp  = {$urandom, $urandom};
            a    = tmp[AW-1:0];
            a[2:0] = mis ? 3'($urandom_range(1, 7)) : 3'b000;
            wd   = {$urandom, $urandom};
            ws   = 8'($urandom_range(255));
            s_rdy_dly = $urandom_range(0, 3);
            s_rsp_dly = $urandom_range(1, TO);
            s_err     = ($urandom_range(3) == 0);
            s_mute    = ($urandom_range(7) == 0);
            s_late    = s_mute ? $urandom_range(4, 5) : 0;
            s_rdata   = {$urandom, $urandom};
            bp        = $urandom_range(0, 2);

            if (mis) begin
                er = 2'b10; ed = '0; elat = 1;
            end else if (s_mute) begin
                er = 2'b11; ed = '0; elat = 2 + s_rdy_dly + TO;
            end else begin
                er = s_err ? 2'b10 : 2'b00; ed = s_rdata; elat = 2 + s_rdy_dly + s_rsp_dly;
            end

            if (wr) begin
                axi_write(a, wd, ws, bp, r, lat);
            end else begin
                axi_read(a, bp, d, r, lat);
                chk("rnd_r_data", d, ed);
            end
            chk("rnd_resp", 64'(r), 64'(er));
            chk("rnd_latency", 64'(lat), 64'(elat));
            chk_req(!mis, wr, a, wd, ws);
        end

        repeat (12) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
